game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter PIPE_DIV, default 524288, meaning Clk cycles between pipe-advance pulses.
REQ-002 SHALL have parameter PHYS_DIV, default 1048576, meaning Clk cycles between physics-step pulses.
REQ-003 SHALL have parameter CD_DIV, default 50000000, meaning Clk cycles per countdown step.
REQ-004 Clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 Start  input  1  one-cycle debounced start pulse.
REQ-007 Ack  input  1  one-cycle debounced acknowledge pulse.
REQ-008 Jump  input  1  one-cycle debounced jump pulse.
REQ-009 Collide  input  1  level from the obstacle checker; bird overlaps a pipe or the screen edge.
REQ-010 PipePassed  input  1  one-cycle pulse; bird cleared a pipe.
REQ-011 Clear  output  1  one-cycle pulse; re-initialise pipe RAM and flight physics.
REQ-012 Pipe_En  output  1  one-cycle pipe-advance enable.
REQ-013 Phys_En  output  1  one-cycle physics-step enable.
REQ-014 Jump_Out  output  1  jump request, valid only with Phys_En.
REQ-015 Countdown  output  2  remaining countdown value, for the SSD.
REQ-016 Score  output  8  current score.
REQ-017 HiScore  output  8  best score since reset.
REQ-018 q_Initial, q_Countdown, q_Run, q_Lose  output  1 each  one-hot state flags.

Function
REQ-019 FSM states SHALL be INIT, COUNTDOWN, RUN and LOSE, one-hot encoded, with all outputs registered.
REQ-020 In INIT, a Start pulse SHALL move the FSM to COUNTDOWN.
- On that move: Clear pulses for 1 cycle, Score becomes 0, Countdown becomes 3.
- If Start and Ack arrive in the same cycle, Start wins.
REQ-021 In COUNTDOWN, the divider SHALL decrement Countdown each time it reaches CD_DIV.
- On the expiry that finds Countdown=1, Countdown becomes 0 and the FSM moves to RUN.
- Start, Jump, Collide and PipePassed are ignored in this state.
REQ-022 Both divider counters SHALL reset to 0 on entry to RUN.
- First Pipe_En: exactly PIPE_DIV cycles after the RUN entry edge, then every PIPE_DIV cycles.
- First Phys_En: exactly PHYS_DIV cycles after the RUN entry edge, then every PHYS_DIV cycles.
- Pipe_En and Phys_En may coincide.
REQ-023 A Jump pulse in RUN SHALL set a pending flag.
- Jump_Out=1 in the next Phys_En cycle, and the flag clears.
- If Jump arrives in the same cycle as Phys_En, it is serviced by that Phys_En.
- Multiple Jumps between steps collapse to one.
REQ-024 In RUN, PipePassed SHALL increment Score, saturating at 255.
REQ-025 In RUN, Collide=1 SHALL move the FSM to LOSE on the next edge.
- A PipePassed in the same cycle does not increment Score.
- Pipe_En and Phys_En are forced to 0 in that cycle.
REQ-026 In LOSE, all enables SHALL be 0 and Score SHALL be held.
- HiScore updates to max(HiScore, Score) one cycle after LOSE entry.
REQ-027 In LOSE, an Ack pulse SHALL move the FSM to INIT.
- If Start and Ack arrive in the same cycle, Ack wins and Start is dropped.
REQ-028 Outside RUN, Pipe_En, Phys_En and Jump_Out SHALL be 0 and the pending jump flag SHALL be cleared.
REQ-029 Divider widths SHALL be 32 bits; terminal compare is count==DIV-1.

Reset
REQ-030 While reset_n=0, the block SHALL be in state INIT with:
- q_Initial=1 and all other state flags 0;
- Clear=0, Pipe_En=0, Phys_En=0, Jump_Out=0;
- Countdown=0, Score=0, HiScore=0, dividers 0, pending jump flag 0.
REQ-031 Deassertion SHALL be taken synchronously to Clk (two-flop reset synchroniser inside the block).
- Reset mid-RUN aborts immediately with no Clear pulse.

Structure
REQ-032 The state encoding localparams and the default divider values SHALL live in shared package flappy_pkg.
REQ-033 One sub-module, tick_divider (parameter DIV, inputs clear/enable, output one-cycle pulse), SHALL be instantiated three times.

Verification (bench parameters PIPE_DIV=4, PHYS_DIV=8, CD_DIV=3)
REQ-034 Reset then Start at cycle 10 -> Clear=1 at cycle 11 and Countdown steps 3,2,1,0 every 3 cycles; q_Run=1 after 9 cycles; first Pipe_En 4 cycles after RUN entry, first Phys_En 8 cycles after.
REQ-035 In RUN, three Jump pulses between two Phys_En -> exactly one Jump_Out, coincident with the next Phys_En.
REQ-036 256 PipePassed pulses in RUN -> Score=255, saturated; Collide together with a PipePassed -> LOSE, Score unchanged, no enable pulse that cycle.
REQ-037 Game 1 ends with Score=7, then Ack, then game 2 ends with Score=3 -> HiScore=7 after both; Start+Ack together in LOSE -> INIT with no COUNTDOWN.
REQ-038 reset_n low for 1 cycle mid-RUN -> all outputs at reset values, HiScore=0, and no Clear pulse.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy-bird game sequencer: state encoding
// and default divider terminal counts.
package flappy_pkg;

  localparam logic [3:0] ST_INIT      = 4'b0001;
  localparam logic [3:0] ST_COUNTDOWN = 4'b0010;
  localparam logic [3:0] ST_RUN       = 4'b0100;
  localparam logic [3:0] ST_LOSE      = 4'b1000;

  typedef enum logic [3:0] {
    INIT      = ST_INIT,
    COUNTDOWN = ST_COUNTDOWN,
    RUN       = ST_RUN,
    LOSE      = ST_LOSE
  } state_t;

  localparam int unsigned PIPE_DIV_DEF = 524288;
  localparam int unsigned PHYS_DIV_DEF = 1048576;
  localparam int unsigned CD_DIV_DEF   = 50000000;

endpackage

// File: rtl/tick_divider.sv
// Free-running 32-bit cycle divider. The pulse flags the last cycle of each
// DIV-cycle period; the parent registers it, so the registered pulse lands
// exactly DIV cycles after the counter was released from clear.
module tick_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic Clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic pulse
);

  localparam logic [31:0] TERM = 32'(DIV - 1);

  logic [31:0] count;

  assign pulse = enable && !clear && (count == TERM);

  // Count enabled cycles, wrapping at the terminal value; clear holds it at 0.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == TERM) ? '0 : count + 32'd1;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game sequencer: INIT -> COUNTDOWN -> RUN -> LOSE control FSM with the
// pipe/physics/countdown timebases, jump request latching and scoring.
// Every output is a flop or a direct decode of the one-hot state flops.
module game_sequencer
  import flappy_pkg::*;
#(
  parameter int unsigned PIPE_DIV = PIPE_DIV_DEF,
  parameter int unsigned PHYS_DIV = PHYS_DIV_DEF,
  parameter int unsigned CD_DIV   = CD_DIV_DEF
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       Start,
  input  logic       Ack,
  input  logic       Jump,
  input  logic       Collide,
  input  logic       PipePassed,
  output logic       Clear,
  output logic       Pipe_En,
  output logic       Phys_En,
  output logic       Jump_Out,
  output logic [1:0] Countdown,
  output logic [7:0] Score,
  output logic [7:0] HiScore,
  output logic       q_Initial,
  output logic       q_Countdown,
  output logic       q_Run,
  output logic       q_Lose
);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [1:0] rst_sync;
  logic       rst_n_s;
  state_t     state, state_nx;
  logic       pending, pending_nx;
  logic       clear_nx, pipe_nx, phys_nx, jump_nx;
  logic [1:0] cd_nx;
  logic [7:0] score_nx, hi_nx;
  logic       in_cd, in_run, run_live;
  logic       cd_tick, pipe_tick, phys_tick;

  // Assert reset immediately, release it two clock edges later.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_s = rst_sync[1];

  assign in_cd    = (state == COUNTDOWN);
  assign in_run   = (state == RUN);
  // A collision cycle produces no enables, so the step that would land with
  // the LOSE transition is swallowed.
  assign run_live = in_run && !Collide;

  tick_divider #(.DIV(CD_DIV)) u_cd_div (
    .Clk(Clk), .reset_n(rst_n_s), .clear(!in_cd), .enable(in_cd), .pulse(cd_tick)
  );
  tick_divider #(.DIV(PIPE_DIV)) u_pipe_div (
    .Clk(Clk), .reset_n(rst_n_s), .clear(!in_run), .enable(run_live), .pulse(pipe_tick)
  );
  tick_divider #(.DIV(PHYS_DIV)) u_phys_div (
    .Clk(Clk), .reset_n(rst_n_s), .clear(!in_run), .enable(run_live), .pulse(phys_tick)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_nx   = state;
    clear_nx   = 1'b0;
    pipe_nx    = 1'b0;
    phys_nx    = 1'b0;
    jump_nx    = 1'b0;
    pending_nx = 1'b0;
    cd_nx      = Countdown;
    score_nx   = Score;
    hi_nx      = HiScore;
    case (state)
      INIT: begin
        if (Start) begin
          state_nx = COUNTDOWN;
          clear_nx = 1'b1;
          score_nx = 8'd0;
          cd_nx    = 2'd3;
        end
      end
      COUNTDOWN: begin
        if (cd_tick) begin
          if (Countdown <= 2'd1) begin
            cd_nx    = 2'd0;
            state_nx = RUN;
          end else begin
            cd_nx = Countdown - 2'd1;
          end
        end
      end
      RUN: begin
        if (Collide) begin
          state_nx = LOSE;
        end else begin
          pipe_nx = pipe_tick;
          phys_nx = phys_tick;
          // A jump seen on the step edge itself rides out with that step.
          if (phys_tick) jump_nx = pending || Jump;
          else           pending_nx = pending || Jump;
          if (PipePassed) score_nx = sat_inc(Score);
        end
      end
      LOSE: begin
        if (Score > HiScore) hi_nx = Score;
        if (Ack) state_nx = INIT;
      end
      default: state_nx = INIT;
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state     <= INIT;
      pending   <= 1'b0;
      Clear     <= 1'b0;
      Pipe_En   <= 1'b0;
      Phys_En   <= 1'b0;
      Jump_Out  <= 1'b0;
      Countdown <= 2'd0;
      Score     <= 8'd0;
      HiScore   <= 8'd0;
    end else begin
      state     <= state_nx;
      pending   <= pending_nx;
      Clear     <= clear_nx;
      Pipe_En   <= pipe_nx;
      Phys_En   <= phys_nx;
      Jump_Out  <= jump_nx;
      Countdown <= cd_nx;
      Score     <= score_nx;
      HiScore   <= hi_nx;
    end
  end

  assign q_Initial   = (state == INIT);
  assign q_Countdown = (state == COUNTDOWN);
  assign q_Run       = (state == RUN);
  assign q_Lose      = (state == LOSE);

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer with short divider periods.
module tb_game_sequencer;

  localparam int unsigned PIPE_DIV = 4;
  localparam int unsigned PHYS_DIV = 8;
  localparam int unsigned CD_DIV   = 3;

  localparam logic [3:0] QI = 4'b0001;
  localparam logic [3:0] QC = 4'b0010;
  localparam logic [3:0] QR = 4'b0100;
  localparam logic [3:0] QL = 4'b1000;

  logic       Clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       Start = 1'b0, Ack = 1'b0, Jump = 1'b0, Collide = 1'b0, PipePassed = 1'b0;
  logic       Clear, Pipe_En, Phys_En, Jump_Out;
  logic [1:0] Countdown;
  logic [7:0] Score, HiScore;
  logic       q_Initial, q_Countdown, q_Run, q_Lose;

  typedef struct packed {
    logic [3:0] q;
    logic       clr, pe, fe, jo;
    logic [1:0] cd;
    logic [7:0] score, hi;
  } snap_t;

  typedef struct packed {
    logic start, ack, jump, collide, pp;
  } in_t;

  typedef struct {
    in_t   in;
    snap_t want;
    snap_t mask;
    string tag;
  } vec_t;

  typedef struct {
    snap_t want;
    snap_t mask;
    string tag;
  } exp_t;

  vec_t  tbl[$];
  exp_t  sb[$];
  int    errors = 0;
  int    checks = 0;
  snap_t m_all, m_noen;

  game_sequencer #(.PIPE_DIV(PIPE_DIV), .PHYS_DIV(PHYS_DIV), .CD_DIV(CD_DIV)) dut (
    .Clk(Clk), .reset_n(reset_n), .Start(Start), .Ack(Ack), .Jump(Jump),
    .Collide(Collide), .PipePassed(PipePassed), .Clear(Clear), .Pipe_En(Pipe_En),
    .Phys_En(Phys_En), .Jump_Out(Jump_Out), .Countdown(Countdown), .Score(Score),
    .HiScore(HiScore), .q_Initial(q_Initial), .q_Countdown(q_Countdown),
    .q_Run(q_Run), .q_Lose(q_Lose)
  );

  always #5 Clk = ~Clk;

  function automatic snap_t snap(logic [3:0] q, logic clr, logic pe, logic fe, logic jo,
                                 logic [1:0] cd, logic [7:0] sc, logic [7:0] hi);
    snap_t s;
    s.q = q; s.clr = clr; s.pe = pe; s.fe = fe; s.jo = jo;
    s.cd = cd; s.score = sc; s.hi = hi;
    return s;
  endfunction

  function automatic in_t inp(logic st, logic ak, logic jp, logic co, logic pp);
    in_t i;
    i.start = st; i.ack = ak; i.jump = jp; i.collide = co; i.pp = pp;
    return i;
  endfunction

  function automatic snap_t observed();
    return snap({q_Lose, q_Run, q_Countdown, q_Initial}, Clear, Pipe_En, Phys_En,
                Jump_Out, Countdown, Score, HiScore);
  endfunction

  function automatic logic [1:0] cd_after(int i);
    return 2'(3 - i / 3);
  endfunction

  function void add(in_t i, snap_t w, string tag);
    vec_t v;
    v.in = i; v.want = w; v.mask = m_all; v.tag = tag;
    tbl.push_back(v);
  endfunction

  task automatic drive(input in_t i);
    Start = i.start; Ack = i.ack; Jump = i.jump; Collide = i.collide; PipePassed = i.pp;
  endtask

  task automatic push(input snap_t w, input snap_t m, input string tag);
    exp_t e;
    e.want = w; e.mask = m; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t  e;
    snap_t a;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty actual=none required=entry");
      return;
    end
    e = sb.pop_front();
    a = observed();
    if ((a & e.mask) !== (e.want & e.mask)) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (q,clr,pe,fe,jo,cd,score,hi)",
               e.tag, a & e.mask, e.want & e.mask);
    end
  endtask

  // Apply one cycle of inputs, then compare the outputs that edge produced.
  task automatic cyc(input in_t i, input snap_t w, input snap_t m, input string tag);
    drive(i);
    push(w, m, tag);
    @(posedge Clk);
    #1;
    check_pop();
  endtask

  task automatic countdown_to_run(input logic [7:0] hi, input string tag);
    for (int i = 1; i <= 8; i++)
      cyc(inp(0,0,0,0,0), snap(QC,0,0,0,0,cd_after(i),0,hi), m_all, {tag, "_cd"});
    cyc(inp(0,0,0,0,0), snap(QR,0,0,0,0,0,0,hi), m_all, {tag, "_run_entry"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_all  = '1;
    m_noen = '1;
    m_noen.pe = 1'b0;
    m_noen.fe = 1'b0;

    // Game 1: start, countdown with ignored inputs, run with jumps, score 7, lose.
    for (int i = 0; i < 3; i++) add(inp(0,0,0,0,0), snap(QI,0,0,0,0,0,0,0), "idle");
    add(inp(0,1,0,0,0), snap(QI,0,0,0,0,0,0,0), "ack_in_init");
    add(inp(1,0,0,0,0), snap(QC,1,0,0,0,3,0,0), "start_to_cd");
    add(inp(0,0,0,1,0), snap(QC,0,0,0,0,3,0,0), "cd_ignore_collide");
    add(inp(0,0,1,0,0), snap(QC,0,0,0,0,3,0,0), "cd_ignore_jump");
    add(inp(0,0,0,0,0), snap(QC,0,0,0,0,2,0,0), "cd_step_2");
    add(inp(0,0,0,0,1), snap(QC,0,0,0,0,2,0,0), "cd_ignore_pass");
    add(inp(1,0,0,0,0), snap(QC,0,0,0,0,2,0,0), "cd_ignore_start");
    for (int i = 0; i < 3; i++) add(inp(0,0,0,0,0), snap(QC,0,0,0,0,1,0,0), "cd_step_1");
    add(inp(0,0,0,0,0), snap(QR,0,0,0,0,0,0,0), "run_entry");
    for (int k = 1; k <= 24; k++) begin
      logic jp, pe, fe, jo;
      jp = (k == 9) || (k == 11) || (k == 13) || (k == 24);
      pe = (k % 4 == 0);
      fe = (k % 8 == 0);
      jo = (k == 16) || (k == 24);
      add(inp(0,0,jp,0,0), snap(QR,0,pe,fe,jo,0,0,0), $sformatf("run_k%0d", k));
    end
    for (int k = 25; k <= 31; k++)
      add(inp(0,0,0,0,1), snap(QR,0,(k == 28),0,0,0,8'(k - 24),0), $sformatf("pass_k%0d", k));
    add(inp(0,0,0,1,0), snap(QL,0,0,0,0,0,7,0), "collide_no_enable");
    add(inp(0,0,1,0,1), snap(QL,0,0,0,0,0,7,7), "lose_hiscore_7");
    add(inp(0,1,0,0,0), snap(QI,0,0,0,0,0,7,7), "ack_to_init");
    add(inp(1,1,0,0,0), snap(QC,1,0,0,0,3,0,7), "start_wins_in_init");

    // Reset state.
    drive(inp(0,0,0,0,0));
    repeat (2) @(posedge Clk);
    #1;
    push(snap(QI,0,0,0,0,0,0,0), m_all, "reset_state");
    check_pop();
    reset_n = 1'b1;

    for (int n = 0; n < tbl.size(); n++) cyc(tbl[n].in, tbl[n].want, tbl[n].mask, tbl[n].tag);

    // Game 2: score 3, HiScore stays 7; Start+Ack in LOSE returns to INIT only.
    countdown_to_run(8'd7, "g2");
    for (int k = 1; k <= 3; k++)
      cyc(inp(0,0,0,0,1), snap(QR,0,0,0,0,0,8'(k),7), m_all, "g2_pass");
    cyc(inp(0,0,0,1,0), snap(QL,0,0,0,0,0,3,7), m_all, "g2_collide");
    cyc(inp(0,0,0,0,0), snap(QL,0,0,0,0,0,3,7), m_all, "g2_hiscore_keeps_7");
    cyc(inp(1,1,0,0,0), snap(QI,0,0,0,0,0,3,7), m_all, "ack_wins_in_lose");
    cyc(inp(0,0,0,0,0), snap(QI,0,0,0,0,0,3,7), m_all, "stay_init");

    // Game 3: score saturation, collision together with a pass.
    cyc(inp(1,0,0,0,0), snap(QC,1,0,0,0,3,0,7), m_all, "g3_start");
    countdown_to_run(8'd7, "g3");
    for (int k = 1; k <= 256; k++)
      cyc(inp(0,0,0,0,1), snap(QR,0,0,0,0,0,(k < 255) ? 8'(k) : 8'd255,7), m_noen,
          $sformatf("sat_k%0d", k));
    for (int k = 257; k <= 263; k++)
      cyc(inp(0,0,0,0,0), snap(QR,0,0,0,0,0,255,7), m_noen, "sat_hold");
    cyc(inp(0,0,0,1,1), snap(QL,0,0,0,0,0,255,7), m_all, "collide_with_pass");
    cyc(inp(0,0,0,0,0), snap(QL,0,0,0,0,0,255,255), m_all, "hiscore_255");

    // Reset pulse in the middle of a run.
    cyc(inp(0,1,0,0,0), snap(QI,0,0,0,0,0,255,255), m_all, "g4_ack");
    cyc(inp(1,0,0,0,0), snap(QC,1,0,0,0,3,0,255), m_all, "g4_start");
    countdown_to_run(8'd255, "g4");
    cyc(inp(0,0,0,0,0), snap(QR,0,0,0,0,0,0,255), m_all, "g4_run");
    cyc(inp(0,0,1,0,0), snap(QR,0,0,0,0,0,0,255), m_all, "g4_jump");
    drive(inp(0,0,0,0,0));
    reset_n = 1'b0;
    #1;
    push(snap(QI,0,0,0,0,0,0,0), m_all, "async_reset");
    check_pop();
    @(posedge Clk);
    #1;
    push(snap(QI,0,0,0,0,0,0,0), m_all, "reset_held");
    check_pop();
    reset_n = 1'b1;
    for (int n = 0; n < 6; n++)
      cyc(inp(0,0,0,0,0), snap(QI,0,0,0,0,0,0,0), m_all, "post_reset_no_clear");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
